// File: rtl/decoder_pkg.sv
// Shared constants, FSM state type and a one-hot helper for the 8-to-3 priority encoder.
package decoder_pkg;

    localparam int N_LINES = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [N_LINES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_LINES-1:0] one;
        one      = '0;
        one[idx] = 1'b1;
        return one;
    endfunction

endpackage

// File: rtl/prio_pick_8_3.sv
// Combinational priority pick: index of the winning set bit and whether any bit is set.
module prio_pick_8_3
    import decoder_pkg::*;
#(
    parameter int HI_FIRST = 1
) (
    input  logic [N_LINES-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Later matches overwrite earlier ones, so the scan order decides the winner.
    always_comb begin
        idx = '0;
        any = |vec;
        if (HI_FIRST != 0) begin
            for (int i = 0; i < N_LINES; i++) begin
                if (vec[i]) idx = i[IDX_W-1:0];
            end
        end else begin
            for (int i = N_LINES - 1; i >= 0; i--) begin
                if (vec[i]) idx = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/priority_encoder_8_3.sv
// Registered priority encoder: captures request lines, presents one index at a time
// with a valid/ready handshake, and flags requests that hit an already-pending line.
module priority_encoder_8_3
    import decoder_pkg::*;
#(
    parameter int HI_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                E,
    input  logic [N_LINES-1:0]  D,
    output logic [IDX_W-1:0]    S,
    output logic                valid,
    input  logic                ready,
    output logic [N_LINES-1:0]  pending,
    output logic                dup
);

    state_t               state_q, state_d;
    logic [N_LINES-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]     s_q, s_d;
    logic                 valid_q, valid_d;
    logic                 dup_q, dup_d;
    logic [N_LINES-1:0]   clr;
    logic [N_LINES-1:0]   cap;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    prio_pick_8_3 #(
        .HI_FIRST (HI_FIRST)
    ) u_pick (
        .vec (pending_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        clr       = (valid_q && ready) ? idx_onehot(s_q) : '0;
        cap       = D & {N_LINES{E}};
        // Clear is applied before the set, so a same-cycle capture re-arms the line.
        pending_d = (pending_q & ~clr) | cap;
        dup_d     = dup_q | (|(cap & pending_q & ~clr));

        state_d = state_q;
        s_d     = s_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    s_d     = pick_idx;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            s_q       <= '0;
            valid_q   <= 1'b0;
            dup_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            s_q       <= s_d;
            valid_q   <= valid_d;
            dup_q     <= dup_d;
        end
    end

    assign S       = s_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign dup     = dup_q;

endmodule

// File: tb/tb_priority_encoder_8_3.sv
// Self-checking bench: two DUT instances (HI_FIRST=1 and 0) checked every cycle against
// a scoreboard fed by a reference model, plus directed constant checks per scenario.
module tb_priority_encoder_8_3;

    typedef struct packed {
        logic [7:0] pend;
        logic [2:0] s;
        logic       v;
        logic       dup;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       e = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] d = 8'h00;

    logic [2:0] s_hi, s_lo;
    logic       valid_hi, valid_lo;
    logic [7:0] pending_hi, pending_lo;
    logic       dup_hi, dup_lo;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] m_pend [2];
    logic [2:0] m_s [2];
    logic       m_valid [2];
    logic       m_dup [2];
    obs_t       exp_q [$];

    always #5 clk = ~clk;

    priority_encoder_8_3 #(.HI_FIRST(1)) dut_hi (
        .clk (clk), .rst (rst), .E (e), .D (d), .S (s_hi),
        .valid (valid_hi), .ready (ready), .pending (pending_hi), .dup (dup_hi)
    );

    priority_encoder_8_3 #(.HI_FIRST(0)) dut_lo (
        .clk (clk), .rst (rst), .E (e), .D (d), .S (s_lo),
        .valid (valid_lo), .ready (ready), .pending (pending_lo), .dup (dup_lo)
    );

    function automatic logic [2:0] ref_pick(input logic [7:0] v, input int hi);
        if (hi != 0) begin
            for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
        end else begin
            for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // k=0 models the HI_FIRST=1 instance, k=1 the HI_FIRST=0 instance.
    task automatic model_step(input int k);
        logic [7:0] clr_m;
        logic [7:0] cap_m;
        if (rst) begin
            m_pend[k] = 8'h00; m_s[k] = 3'd0; m_valid[k] = 1'b0; m_dup[k] = 1'b0;
            return;
        end
        clr_m = 8'h00;
        if (m_valid[k] && ready) begin
            clr_m[m_s[k]] = 1'b1;
            $display("[TB] t=%0t inst=%s accept idx=%0d", $time, (k == 0) ? "hi" : "lo", m_s[k]);
        end
        cap_m = e ? d : 8'h00;
        if ((cap_m & m_pend[k] & ~clr_m) != 8'h00) m_dup[k] = 1'b1;
        if (!m_valid[k]) begin
            if (m_pend[k] != 8'h00) begin
                m_s[k] = ref_pick(m_pend[k], (k == 0) ? 1 : 0);
                m_valid[k] = 1'b1;
            end
        end else if (ready) begin
            m_valid[k] = 1'b0;
        end
        m_pend[k] = (m_pend[k] & ~clr_m) | cap_m;
    endtask

    task automatic cycle();
        obs_t exp_o;
        obs_t act_o;
        model_step(0);
        exp_q.push_back({m_pend[0], m_s[0], m_valid[0], m_dup[0]});
        model_step(1);
        exp_q.push_back({m_pend[1], m_s[1], m_valid[1], m_dup[1]});
        @(posedge clk);
        #1;
        exp_o = exp_q.pop_front();
        act_o = {pending_hi, s_hi, valid_hi, dup_hi};
        tests_run++;
        if (act_o !== exp_o) begin
            tests_failed++;
            $display("FAIL scoreboard_hi t=%0t actual pend=%h S=%0d valid=%b dup=%b required pend=%h S=%0d valid=%b dup=%b",
                     $time, act_o.pend, act_o.s, act_o.v, act_o.dup, exp_o.pend, exp_o.s, exp_o.v, exp_o.dup);
        end
        exp_o = exp_q.pop_front();
        act_o = {pending_lo, s_lo, valid_lo, dup_lo};
        tests_run++;
        if (act_o !== exp_o) begin
            tests_failed++;
            $display("FAIL scoreboard_lo t=%0t actual pend=%h S=%0d valid=%b dup=%b required pend=%h S=%0d valid=%b dup=%b",
                     $time, act_o.pend, act_o.s, act_o.v, act_o.dup, exp_o.pend, exp_o.s, exp_o.v, exp_o.dup);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; e = 1'b1; d = 8'hFF; ready = 1'b1;
        cycle();
        tests_run++;
        if ({pending_hi, s_hi, valid_hi, dup_hi} !== 13'h0 || {pending_lo, s_lo, valid_lo, dup_lo} !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_state actual hi=%h lo=%h required 0000", {pending_hi, s_hi, valid_hi, dup_hi},
                     {pending_lo, s_lo, valid_lo, dup_lo});
        end
        rst = 1'b0; d = 8'h00; ready = 1'b0;
    endtask

    task automatic test_basic();
        e = 1'b1; d = 8'h24; ready = 1'b1;
        cycle();
        d = 8'h00;
        cycle();
        tests_run++;
        if (s_hi !== 3'd5 || valid_hi !== 1'b1 || s_lo !== 3'd2 || valid_lo !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_first actual hi S=%0d v=%b lo S=%0d v=%b required hi 5/1 lo 2/1", s_hi, valid_hi, s_lo, valid_lo);
        end
        cycle();
        cycle();
        tests_run++;
        if (s_hi !== 3'd2 || valid_hi !== 1'b1 || s_lo !== 3'd5 || valid_lo !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_second actual hi S=%0d v=%b lo S=%0d v=%b required hi 2/1 lo 5/1", s_hi, valid_hi, s_lo, valid_lo);
        end
        cycle();
        tests_run++;
        if (pending_hi !== 8'h00 || valid_hi !== 1'b0 || pending_lo !== 8'h00 || valid_lo !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_drain actual hi pend=%h v=%b lo pend=%h v=%b required 00/0", pending_hi, valid_hi, pending_lo, valid_lo);
        end
        ready = 1'b0;
    endtask

    task automatic test_hold_stable();
        ready = 1'b0; d = 8'h81;
        cycle();
        d = 8'h00;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            tests_run++;
            if (s_lo !== 3'd0 || valid_lo !== 1'b1) begin
                tests_failed++;
                $display("FAIL hold_stable_lo cycle=%0d actual S=%0d v=%b required S=0 v=1", i, s_lo, valid_lo);
            end
        end
        d = 8'h40;
        cycle();
        tests_run++;
        if (s_hi !== 3'd7 || valid_hi !== 1'b1) begin
            tests_failed++;
            $display("FAIL no_preempt_hi actual S=%0d v=%b required S=7 v=1", s_hi, valid_hi);
        end
        d = 8'h00; ready = 1'b1;
        cycle();
        cycle();
        tests_run++;
        if (s_lo !== 3'd6 || valid_lo !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_next_lo actual S=%0d v=%b required S=6 v=1", s_lo, valid_lo);
        end
        for (int i = 0; i < 5; i++) cycle();
        ready = 1'b0;
    endtask

    task automatic test_refire();
        ready = 1'b0; d = 8'h08;
        cycle();
        d = 8'h00;
        cycle();
        d = 8'h08; ready = 1'b1;
        cycle();
        tests_run++;
        if (pending_hi !== 8'h08 || valid_hi !== 1'b0 || dup_hi !== 1'b0) begin
            tests_failed++;
            $display("FAIL refire_capture actual pend=%h v=%b dup=%b required 08/0/0", pending_hi, valid_hi, dup_hi);
        end
        d = 8'h00; ready = 1'b0;
        cycle();
        tests_run++;
        if (s_hi !== 3'd3 || valid_hi !== 1'b1 || dup_hi !== 1'b0) begin
            tests_failed++;
            $display("FAIL refire_present actual S=%0d v=%b dup=%b required 3/1/0", s_hi, valid_hi, dup_hi);
        end
        ready = 1'b1;
        cycle();
        cycle();
        ready = 1'b0;
    endtask

    task automatic test_enable_dup();
        e = 1'b0; d = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests_run++;
            if (pending_hi !== 8'h00 || valid_hi !== 1'b0 || pending_lo !== 8'h00 || valid_lo !== 1'b0) begin
                tests_failed++;
                $display("FAIL enable_block actual pend=%h v=%b required 00/0", pending_hi, valid_hi);
            end
        end
        e = 1'b1; d = 8'h10;
        cycle();
        tests_run++;
        if (dup_hi !== 1'b0) begin
            tests_failed++;
            $display("FAIL dup_first actual dup=%b required 0", dup_hi);
        end
        cycle();
        tests_run++;
        if (dup_hi !== 1'b1 || dup_lo !== 1'b1) begin
            tests_failed++;
            $display("FAIL dup_second actual hi=%b lo=%b required 1", dup_hi, dup_lo);
        end
        d = 8'h00; ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        tests_run++;
        if (dup_hi !== 1'b1) begin
            tests_failed++;
            $display("FAIL dup_sticky actual dup=%b required 1", dup_hi);
        end
        ready = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        rst = 1'b1;
        cycle();
        rst = 1'b0; e = 1'b1; d = 8'h0C; ready = 1'b0;
        cycle();
        d = 8'h00;
        cycle();
        tests_run++;
        if (pending_hi !== 8'h0C || s_hi !== 3'd3 || valid_hi !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_setup actual pend=%h S=%0d v=%b required 0c/3/1", pending_hi, s_hi, valid_hi);
        end
        rst = 1'b1; d = 8'hFF; ready = 1'b1;
        cycle();
        tests_run++;
        if ({pending_hi, s_hi, valid_hi, dup_hi} !== 13'h0 || {pending_lo, s_lo, valid_lo, dup_lo} !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_in_hold actual hi=%h lo=%h required 0000", {pending_hi, s_hi, valid_hi, dup_hi},
                     {pending_lo, s_lo, valid_lo, dup_lo});
        end
        rst = 1'b0; d = 8'h00; ready = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            e     = ($urandom_range(0, 3) != 0);
            d     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        rst = 1'b0; e = 1'b0; d = 8'h00; ready = 1'b0;
    endtask

    initial begin
        m_pend[0] = 8'h00; m_s[0] = 3'd0; m_valid[0] = 1'b0; m_dup[0] = 1'b0;
        m_pend[1] = 8'h00; m_s[1] = 3'd0; m_valid[1] = 1'b0; m_dup[1] = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_hold_stable();
        test_refire();
        test_enable_dup();
        test_reset_in_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/priority_encoder_8_3.md
PRIORITY_ENCODER_8_3 -- requirements
Module: priority_encoder_8_3

Interface
REQ-001 SHALL have parameter HI_FIRST, default 1, meaning: 1 gives index 7 highest priority; 0 gives index 0 highest.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port E  input  1  capture enable; 0 blocks new requests from being captured.
REQ-005 SHALL have port D  input  8  one request bit per line; each bit is sampled every cycle.
REQ-006 SHALL have port S  output  3  registered index of the line being presented.
REQ-007 SHALL have port valid  output  1  S holds a pending index.
REQ-008 SHALL have port ready  input  1  consumer accepts S when valid&&ready at a clock edge.
REQ-009 SHALL have port pending  output  8  registered copy of the pending-request bits.
REQ-010 SHALL have port dup  output  1  sticky flag: a request arrived on a line already pending.

Function
REQ-011 SHALL update pending each cycle as pending_next = (pending & ~clr) | (D & {8{E}}). clr is the one-hot of S when valid&&ready, otherwise 0.
REQ-012 SHALL give a captured set priority over a clear on the same bit in the same cycle; that line therefore re-fires.
REQ-013 SHALL implement FSM states IDLE and HOLD.
REQ-014 In IDLE, when pending != 0, SHALL load S with the highest-priority pending index (per HI_FIRST), set valid=1 and go to HOLD.
REQ-015 In IDLE with pending == 0, SHALL keep valid=0 and hold S at its last value.
REQ-016 Latency: D bit asserted at edge N SHALL appear in pending after edge N. If the FSM is IDLE, valid=1 with its index SHALL follow after edge N+1.
REQ-017 In HOLD with ready=0, SHALL keep S and valid stable; a higher-priority arrival SHALL NOT pre-empt the presented index.
REQ-018 In HOLD with ready=1, SHALL clear the presented bit per REQ-011, drive valid=0 next cycle and return to IDLE.
REQ-019 Maximum throughput SHALL be one accepted index per 2 cycles.
REQ-020 SHALL set dup when E=1 and D&pending != 0, excluding a bit that is being cleared in that same cycle; dup clears only on rst.
REQ-021 SHALL continue serving already-pending lines while E=0.
REQ-022 ready while valid=0 SHALL have no effect.
REQ-023 D=8'h00 with pending=0 SHALL leave all outputs unchanged.

Reset
REQ-024 On rst=1 at a clock edge, SHALL force pending=8'h00, S=3'b000, valid=0, dup=0, FSM=IDLE.
REQ-025 Reset SHALL override all other inputs, including D and ready in the same cycle.
REQ-026 Reset mid-handshake SHALL discard the presented index without reporting it.
REQ-027 The first capture after reset SHALL be D sampled at the first edge with rst=0.

Structure
REQ-028 Shared package decoder_pkg SHALL hold constants N_LINES=8 and IDX_W=3, and the FSM state enum {IDLE, HOLD}.
REQ-029 The priority selection SHALL be a combinational sub-module prio_pick_8_3, with inputs 8-bit vector and HI_FIRST and outputs 3-bit index and any.
REQ-030 Every output SHALL be driven directly from a flop, with no combinational input-to-output paths.

Verification
REQ-031 Reset then D=8'h24 for 1 cycle, ready=1, HI_FIRST=1 -> S=5 valid after 2 edges; S=2 valid 2 cycles later; then pending=0, valid=0.
REQ-032 HI_FIRST=0, D=8'h81 pulse, ready=0 for 5 cycles -> S=0 stays stable with valid=1; after ready=1, S=7 is presented.
REQ-033 S=3 presented, D=8'h08 asserted in the accept cycle -> bit 3 remains pending and S=3 is re-presented; dup stays 0.
REQ-034 E=0, D=8'hFF -> pending stays 0, valid stays 0; then E=1, D=8'h10 twice in a row -> dup=1.
REQ-035 Apply rst=1 in HOLD with pending=8'h0C -> next cycle pending=0, valid=0, S=0, dup=0.
REQ-036 Random D/E/ready for 10k cycles vs reference model -> every captured request is accepted exactly once per capture/clear cycle, and S never changes while valid&&!ready.
